// File: rtl/fetch_queue.sv
// fetch_queue: buffers {PC, instruction} pairs from the fetch stage and
// hands them to decode in order through a valid/ready handshake. The PC
// register write enable is generated here, so a full queue stalls fetch.
// A redirect from execute (flush) discards everything buffered.
// DEPTH is expected to be a power of two, at least 2, so the pointers can
// wrap by plain overflow.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [AW-1:0]            if_pc,
  input  logic [AW-1:0]            if_instr,
  output logic                     if_we,
  input  logic                     flush,
  output logic                     dec_valid,
  output logic [AW-1:0]            dec_pc,
  output logic [AW-1:0]            dec_instr,
  input  logic                     dec_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Head values shown to decode while nothing is buffered: the boot PC
  // paired with a nop, so decode never sees stale data.
  localparam logic [AW-1:0] EMPTY_PC    = AW'(32'h0000_3000);
  localparam logic [AW-1:0] EMPTY_INSTR = '0;

  logic [AW-1:0] pc_mem    [DEPTH];
  logic [AW-1:0] instr_mem [DEPTH];

  logic [PW-1:0] rp;
  logic [PW-1:0] wp;

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Status flags and the handshake: a pop in the same cycle frees a slot,
  // so a full queue still lets the PC advance when decode is taking one.
  always_comb begin
    full      = (count == CW'(DEPTH));
    empty     = (count == '0);
    dec_valid = ~empty;
    if_we     = ~full | (dec_valid & dec_ready);
    pop       = dec_valid & dec_ready & ~flush;
    push      = if_we & ~flush;
  end

  // Head entry presentation; no bypass from the fetch inputs.
  always_comb begin
    dec_pc    = EMPTY_PC;
    dec_instr = EMPTY_INSTR;
    if (!empty) begin
      dec_pc    = pc_mem[rp];
      dec_instr = instr_mem[rp];
    end
  end

  // Pointers and occupancy; reset and flush both empty the queue outright.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
    end else begin
      if (push) begin
        wp <= wp + PW'(1);
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Entry storage, written at the write pointer on every accepted push.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      pc_mem[wp]    <= if_pc;
      instr_mem[wp] <= if_instr;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed test of fetch_queue with a small PC-register
// model upstream (PC advances by 4 when if_we, loads a target on flush or
// reset). Instructions are tagged as 32'h3C00_0000 | pc unless overridden.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_we;
  logic        flush;
  logic        dec_valid;
  logic [31:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_ready;
  logic [2:0]  count;

  int check_count = 0;
  int pass_count  = 0;

  fetch_queue #(.DEPTH(4), .AW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_pc     (if_pc),
    .if_instr  (if_instr),
    .if_we     (if_we),
    .flush     (flush),
    .dec_valid (dec_valid),
    .dec_pc    (dec_pc),
    .dec_instr (dec_instr),
    .dec_ready (dec_ready),
    .count     (count)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_count++;
    if (actual === expected) begin
      pass_count++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, clock it, then update the PC model.
  task automatic applyStimulus(input logic rst, input logic fl,
                               input logic rdy, input logic [31:0] target);
    logic we;
    reset     = rst;
    flush     = fl;
    dec_ready = rdy;
    #1;
    we = if_we;
    @(posedge clk);
    #1;
    if (rst || (fl && we)) begin
      if_pc = target;
    end else if (we) begin
      if_pc = if_pc + 32'd4;
    end
    if_instr = 32'h3C00_0000 | if_pc;
  endtask

  initial begin
    reset     = 1'b1;
    flush     = 1'b0;
    dec_ready = 1'b0;
    if_pc     = 32'h0000_3000;
    if_instr  = 32'h3C00_3000;

    // Reset state
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0000_3000);
    checkOutput("rst_count", {29'd0, count}, 32'd0);
    checkOutput("rst_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("rst_pc", dec_pc, 32'h0000_3000);
    checkOutput("rst_instr", dec_instr, 32'h0000_0000);
    checkOutput("rst_if_we", {31'd0, if_we}, 32'd1);

    // Fill with decode stalled
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("full_count", {29'd0, count}, 32'd4);
    checkOutput("full_if_we", {31'd0, if_we}, 32'd0);
    checkOutput("full_valid", {31'd0, dec_valid}, 32'd1);
    checkOutput("full_pc", dec_pc, 32'h0000_3000);
    checkOutput("full_instr", dec_instr, 32'h3C00_3000);

    // Extra stalled cycle: nothing moves, PC held
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("hold_count", {29'd0, count}, 32'd4);
    checkOutput("hold_pc", dec_pc, 32'h0000_3000);
    checkOutput("hold_if_pc", if_pc, 32'h0000_3010);

    // Decode ready on a full queue frees a slot in the same cycle
    dec_ready = 1'b1;
    #1;
    checkOutput("full_pop_if_we", {31'd0, if_we}, 32'd1);

    // Streaming: one pop and one push per cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput("stream_pc", dec_pc, 32'h0000_3004 + 32'(4 * i));
      checkOutput("stream_instr", dec_instr, 32'h3C00_3004 + 32'(4 * i));
      checkOutput("stream_count", {29'd0, count}, 32'd4);
    end

    // Flush a full queue with decode ready
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3100);
    checkOutput("flush4_count", {29'd0, count}, 32'd0);
    checkOutput("flush4_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("flush4_pc", dec_pc, 32'h0000_3000);

    // Three entries, then flush with decode ready, redirect to 0x3040
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("three_count", {29'd0, count}, 32'd3);
    checkOutput("three_pc", dec_pc, 32'h0000_3100);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3040);
    checkOutput("flush3_count", {29'd0, count}, 32'd0);
    checkOutput("flush3_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("flush3_pc", dec_pc, 32'h0000_3000);
    checkOutput("flush3_instr", dec_instr, 32'h0000_0000);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("redirect_valid", {31'd0, dec_valid}, 32'd1);
    checkOutput("redirect_pc", dec_pc, 32'h0000_3040);
    checkOutput("redirect_instr", dec_instr, 32'h3C00_3040);
    checkOutput("redirect_count", {29'd0, count}, 32'd1);

    // Held empty with decode ready for five cycles
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 32'h0000_3000);
      checkOutput("idle_count", {29'd0, count}, 32'd0);
      checkOutput("idle_valid", {31'd0, dec_valid}, 32'd0);
      checkOutput("idle_instr", dec_instr, 32'h0000_0000);
      checkOutput("idle_if_we", {31'd0, if_we}, 32'd1);
    end

    // From empty with ready still high: push lands, no pop on empty
    if_instr = 32'h3C00_0000;
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
    checkOutput("first_valid", {31'd0, dec_valid}, 32'd1);
    checkOutput("first_pc", dec_pc, 32'h0000_3000);
    checkOutput("first_instr", dec_instr, 32'h3C00_0000);
    checkOutput("first_count", {29'd0, count}, 32'd1);

    // Two entries, then reset with ready and push active
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("two_count", {29'd0, count}, 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0000_3200);
    checkOutput("rst2_count", {29'd0, count}, 32'd0);
    checkOutput("rst2_valid", {31'd0, dec_valid}, 32'd0);
    checkOutput("rst2_if_we", {31'd0, if_we}, 32'd1);
    checkOutput("rst2_pc", dec_pc, 32'h0000_3000);

    // Two pushes, then six push/pop cycles wrapping both pointers
    for (int i = 0; i < 2; i++) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_fill_count", {29'd0, count}, 32'd2);
    checkOutput("wrap_fill_pc", dec_pc, 32'h0000_3200);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 32'h0);
      checkOutput("wrap_pc", dec_pc, 32'h0000_3204 + 32'(4 * i));
      checkOutput("wrap_instr", dec_instr, 32'h3C00_3204 + 32'(4 * i));
      checkOutput("wrap_count", {29'd0, count}, 32'd2);
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
- Consumer end of the fetch stage's PC/instruction interface.
- Buffers {PC, instruction} pairs produced each cycle by the PC register and instruction memory, then hands them in order to decode through a valid/ready handshake.
- Generates the PC-register write enable (`if_we`), so a full queue stalls fetch.
- Discards all buffered entries on a control-flow redirect (`flush`).

Parameters:
- DEPTH, 4: number of entries. Must be a power of 2, ≥2.
- AW, 32: width of the PC and instruction fields.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high; clears the queue.
- if_pc  input  AW  PC currently presented by the PC register.
- if_instr  input  AW  instruction fetched at `if_pc`.
- if_we  output  1  write enable to the PC register; 1 = the PC may advance this cycle.
- flush  input  1  redirect from execute; empties the queue this cycle.
- dec_valid  output  1  head entry is valid.
- dec_pc  output  AW  PC of the head entry.
- dec_instr  output  AW  instruction of the head entry.
- dec_ready  input  1  decode consumes the head entry this cycle.
- count  output  clog2(DEPTH)+1  current occupancy, 0..DEPTH.

Behaviour:
- Storage: DEPTH-entry circular buffer of {pc, instr}.
  - Read pointer `rp`, write pointer `wp`, each clog2(DEPTH) bits; both wrap modulo DEPTH.
  - Occupancy register `count`.
- Derived signals:
  - full = (count == DEPTH); empty = (count == 0).
  - pop = dec_valid & dec_ready & ~flush.
  - if_we = ~full | (dec_valid & dec_ready). Combinational; a pop in the same cycle frees a slot.
  - push = if_we & ~flush.
- Normal cycle:
  - On push, write {if_pc, if_instr} at `wp`; wp <= wp+1.
  - On pop, rp <= rp+1.
  - count <= count + push − pop.
  - Simultaneous push and pop on a full queue is legal: count is unchanged and both pointers advance.
  - Simultaneous push and pop on an empty queue cannot occur, because pop requires dec_valid.
- Outputs:
  - dec_valid = ~empty.
  - dec_pc / dec_instr = entry at `rp` when non-empty.
  - When empty: dec_pc = 32'h0000_3000 and dec_instr = 32'h0000_0000 (nop).
- Latency:
  - An entry pushed at edge N is visible at the head from edge N onward if the queue was empty before.
  - So minimum fetch-to-decode latency is 1 cycle; there is no combinational bypass from `if_*` to `dec_*`.
- Flush:
  - At the next edge: rp <= 0, wp <= 0, count <= 0.
  - No push and no pop that cycle, whatever `dec_ready` is.
  - `if_we` is still driven by the formula above, so the PC register loads the redirect target.
  - First post-flush entry is pushed the following cycle.
- Reset:
  - Same clearing effect as flush; takes priority over flush, push and pop.
  - Reset values: count=0, dec_valid=0, dec_pc=32'h0000_3000, dec_instr=0.
  - `if_we` = 1 while empty.
  - Reset mid-operation discards all entries with no partial outputs.
- Overflow/underflow:
  - No push is possible when full without a pop, because `if_we`=0 holds the PC.
  - `dec_ready` while empty is ignored and pointers do not move.
- Ordering: strict FIFO; entries leave in push order, with no reordering or duplication.

Test Plan:
- Reset, then PC stream 0x3000, 0x3004, … with dec_ready=0 → after 4 pushes count=4, if_we=0, dec_pc=0x3000, PC held at 0x3010.
- Continue with dec_ready=1 every cycle → one pop and one push per cycle; dec_pc steps 0x3000, 0x3004, 0x3008 …; count stays 4 and if_we=1.
- From empty, present 0x3000/0x3C000000 → next cycle dec_valid=1, dec_pc=0x3000, dec_instr=0x3C000000.
- Queue holding 3 entries, flush=1 with dec_ready=1 → next cycle count=0, dec_valid=0, dec_pc=0x3000; pushed redirect PC 0x3040 appears at head one cycle later.
- dec_ready=1 held while empty for 5 cycles → count stays 0, no pointer movement, dec_instr=0.
- Fill 2 entries, assert reset with dec_ready=1 and push active → next cycle count=0, if_we=1, then 6 push/pop cycles check pointer wrap and correct order.
